mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Pipeline M stage: EX/MEM register plus a three-state handshake controller
// that stalls the pipe while a load or store is outstanding on the data-memory port.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RFWEE,
  input  logic        MtoRFSelE,
  input  logic        DMWEE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] DMWDE,
  input  logic [4:0]  rtdE,
  output logic        RFWEM,
  output logic        MtoRFSelM,
  output logic [31:0] ALUOutM,
  output logic [31:0] DMRD,
  output logic [4:0]  rtdM,
  output logic        StallM,
  output logic        dmReq,
  output logic        dmWe,
  output logic [31:0] dmAddr,
  output logic [31:0] dmWData,
  input  logic        dmAck,
  input  logic [31:0] dmRData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic        rfwe_p0;
  logic        mtorf_p0;
  logic        dmwe_p0;
  logic [31:0] alu_p0;
  logic [31:0] wd_p0;
  logic [4:0]  rtd_p0;
  logic [31:0] rdata_p0;
  logic        vld_p0;
  logic        busy;

  // A bubble carries all-zero controls, so it never counts as a memory op.
  assign vld_p0 = mtorf_p0 | dmwe_p0;
  assign busy   = (state == BUSY);

  always_comb begin
    StallM = 1'b0;
    case (state)
      IDLE:    StallM = vld_p0;
      BUSY:    StallM = 1'b1;
      default: StallM = 1'b0;
    endcase
  end

  // E -> M boundary: EX/MEM register advances whenever M is not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfwe_p0  <= 1'b0;
      mtorf_p0 <= 1'b0;
      dmwe_p0  <= 1'b0;
      alu_p0   <= 32'd0;
      wd_p0    <= 32'd0;
      rtd_p0   <= 5'd0;
    end else if (!StallM) begin
      rfwe_p0  <= RFWEE;
      mtorf_p0 <= MtoRFSelE;
      dmwe_p0  <= DMWEE;
      alu_p0   <= ALUOutE;
      wd_p0    <= DMWDE;
      rtd_p0   <= rtdE;
    end
  end

  // M -> memory handshake; acks outside BUSY fall through untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdata_p0 <= 32'd0;
    end else begin
      case (state)
        IDLE: if (vld_p0) state <= BUSY;
        BUSY: begin
          if (dmAck) begin
            if (mtorf_p0) rdata_p0 <= dmRData;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dmReq   = busy;
  assign dmWe    = busy & dmwe_p0;
  assign dmAddr  = busy ? alu_p0 : 32'd0;
  assign dmWData = busy ? wd_p0  : 32'd0;

  // Write enable is withheld while stalled so a load writes the RF only in DONE.
  assign RFWEM     = rfwe_p0 & ~StallM;
  assign MtoRFSelM = mtorf_p0;
  assign ALUOutM   = alu_p0;
  assign rtdM      = rtd_p0;
  assign DMRD      = rdata_p0;

endmodule
